// File: rtl/dma_periph_pkg.sv
// Shared types for the DMA peripheral request scheduler.
// A slot is one (peripheral, direction) pair: slot = 2*(periph-1) + dir.
package dma_periph_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    BUSY  = 2'd2,
    CLEAR = 2'd3
  } state_t;

  typedef enum logic {
    DIR_TX = 1'b0,
    DIR_RX = 1'b1
  } dir_t;

  localparam int NUM_SLOTS = 62;

  typedef logic [5:0] slot_t;

  function automatic slot_t to_slot(input logic [4:0] periph, input dir_t dir);
    logic [4:0] pm1;
    pm1 = periph - 5'd1;
    return {pm1, logic'(dir)};
  endfunction

  function automatic logic [4:0] slot_periph(input slot_t s);
    return s[5:1] + 5'd1;
  endfunction

  function automatic dir_t slot_dir(input slot_t s);
    return dir_t'(s[0]);
  endfunction

endpackage

// File: rtl/dma_rr_arbiter.sv
// Round-robin find-first-set: returns the first set request strictly after
// ptr, wrapping around, so the slot at ptr itself is checked last.
module dma_rr_arbiter
  import dma_periph_pkg::*;
#(
  parameter int N = NUM_SLOTS
) (
  input  logic [N-1:0] req,
  input  slot_t        ptr,
  output slot_t        gnt,
  output logic         gnt_vld
);

  // Scan from ptr+1 through ptr (wrapping), keeping the first hit
  always_comb begin
    slot_t idx;
    gnt     = '0;
    gnt_vld = 1'b0;
    idx     = '0;
    for (int i = 1; i <= N; i++) begin
      idx = slot_t'((int'(ptr) + i) % N);
      if (!gnt_vld && req[idx]) begin
        gnt     = idx;
        gnt_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dma_periph_req_sched.sv
// Peripheral request scheduler: samples tx/rx request levels, round-robin
// picks one (peripheral, direction) job, offers it to the DMA engine, then
// drives the matching clear line until the peripheral drops its request.
// Optional watchdog on BUSY/CLEAR enabled by defining DMA_PERIPH_TIMEOUT_EN.
module dma_periph_req_sched
  import dma_periph_pkg::*;
#(
  parameter int NUM_PERIPH  = 31,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_PERIPH:1]   periph_tx_req,
  input  logic [NUM_PERIPH:1]   periph_rx_req,
  input  logic [NUM_PERIPH:1]   periph_en,
  output logic [NUM_PERIPH:1]   periph_tx_clr,
  output logic [NUM_PERIPH:1]   periph_rx_clr,
  output logic                  xfer_valid,
  input  logic                  xfer_ready,
  output logic [4:0]            xfer_periph,
  output logic                  xfer_dir,
  input  logic                  xfer_done,
  output logic                  busy,
  output logic                  timeout_err
);

  localparam int N_SLOTS = 2 * NUM_PERIPH;

  logic [NUM_PERIPH:1] tx_p0, rx_p0, en_p0;
  logic [N_SLOTS-1:0]  cand;
  slot_t               arb_gnt;
  logic                arb_vld;
  state_t              state, state_nxt;
  slot_t               win, ptr;
  logic                win_ld, ptr_ld;
  logic                win_req;
  logic                clr_on;
  logic                tmo_hit;

  // Stage p0: request, enable sampling; everything downstream sees these
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_p0 <= '0;
      rx_p0 <= '0;
      en_p0 <= '0;
    end else begin
      tx_p0 <= periph_tx_req;
      rx_p0 <= periph_rx_req;
      en_p0 <= periph_en;
    end
  end

  // Candidate vector in slot order: tx of a peripheral precedes its rx
  always_comb begin
    cand = '0;
    for (int p = 1; p <= NUM_PERIPH; p++) begin
      cand[to_slot(5'(p), DIR_TX)] = tx_p0[5'(p)] & en_p0[5'(p)];
      cand[to_slot(5'(p), DIR_RX)] = rx_p0[5'(p)] & en_p0[5'(p)];
    end
  end

  dma_rr_arbiter #(.N(N_SLOTS)) u_arb (
    .req     (cand),
    .ptr     (ptr),
    .gnt     (arb_gnt),
    .gnt_vld (arb_vld)
  );

  // Sampled request level of the committed job, ignoring its enable
  assign win_req = (slot_dir(win) == DIR_RX) ? rx_p0[slot_periph(win)]
                                             : tx_p0[slot_periph(win)];

  // Next-state logic; a latched job runs to completion regardless of req/en
  always_comb begin
    state_nxt = state;
    win_ld    = 1'b0;
    ptr_ld    = 1'b0;
    case (state)
      IDLE: begin
        if (arb_vld) begin
          win_ld    = 1'b1;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        if (xfer_ready) begin
          ptr_ld    = 1'b1;
          state_nxt = xfer_done ? CLEAR : BUSY;
        end
      end
      BUSY: begin
        if (xfer_done || tmo_hit) state_nxt = CLEAR;
      end
      CLEAR: begin
        if (!win_req || tmo_hit) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p1: FSM state, committed winner, round-robin pointer, clear enable
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      win    <= '0;
      ptr    <= slot_t'(N_SLOTS - 1);
      clr_on <= 1'b0;
    end else begin
      state  <= state_nxt;
      if (win_ld) win <= arb_gnt;
      if (ptr_ld) ptr <= win;
      clr_on <= (state == CLEAR) && (state_nxt == CLEAR);
    end
  end

`ifdef DMA_PERIPH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cyc_cnt;

  assign tmo_hit = (cyc_cnt == CNT_W'(TIMEOUT_CYC - 1));

  // Watchdog restarts on every state change and counts while parked in BUSY/CLEAR
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cyc_cnt <= '0;
    end else if (state_nxt != state) begin
      cyc_cnt <= '0;
    end else if (state == BUSY || state == CLEAR) begin
      cyc_cnt <= cyc_cnt + CNT_W'(1);
    end
  end

  // Error pulse only when expiry, not normal completion, forces the exit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= tmo_hit && (((state == BUSY) && !xfer_done) ||
                                 ((state == CLEAR) && win_req));
    end
  end
`else
  assign tmo_hit     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign xfer_valid  = (state == GRANT);
  assign busy        = (state != IDLE);
  assign xfer_periph = busy ? slot_periph(win) : 5'd0;
  assign xfer_dir    = busy ? win[0] : 1'b0;

  // One-hot clear of the committed slot, only while clearing
  always_comb begin
    periph_tx_clr = '0;
    periph_rx_clr = '0;
    if (state == CLEAR && clr_on) begin
      if (slot_dir(win) == DIR_RX) periph_rx_clr[slot_periph(win)] = 1'b1;
      else                         periph_tx_clr[slot_periph(win)] = 1'b1;
    end
  end

endmodule
